// File: rtl/dmem_port_arbiter_if.sv
// Bundles both requester ports and the DataMemory control/data bus of the arbiter.
// Latency: none, wires only.
// Backpressure: req/ack per requester; req stays high until its ack pulse.
interface dmem_port_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    // Requester port 0 (CPU load/store path)
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          ack0;
    logic [DW-1:0] rdata0;

    // Requester port 1 (loader/debug/DMA)
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          ack1;
    logic [DW-1:0] rdata1;

    // DataMemory side
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Status
    logic          busy;
    logic          grant_id;

    // Requesters plus the memory model drive this side
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        input  busy, grant_id
    );

    // The arbiter sits on this side
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, rdata0, ack1, rdata1,
        output mem_read, mem_write, mem_addr, mem_wdata,
        output busy, grant_id
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two req/ack requesters.
// Latency: grant at edge k, memory controls held MEM_LAT cycles, ack pulses in cycle k+MEM_LAT+1.
// Backpressure: one access in flight; requests seen only in IDLE, the loser waits at most one access.
module dmem_port_arbiter #(
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int MEM_LAT = 1
) (
    input  logic                CLK,
    input  logic                Reset_L,
    dmem_port_arbiter_if.slave  bus
);

    // Counter only has to hold MEM_LAT-1; keep at least one bit for MEM_LAT=1.
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          ack0_q,      ack0_d;
    logic          ack1_q,      ack1_d;
    logic [DW-1:0] rdata0_q,    rdata0_d;
    logic [DW-1:0] rdata1_q,    rdata1_d;
    logic          mem_read_q,  mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          grant_id_q,  grant_id_d;

    logic          winner;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Next-state, grant selection and memory-control sequencing
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_id_d  = grant_id_q;

        // On a tie the port that did not own the last access wins.
        if (bus.req0 && bus.req1) begin
            winner = ~grant_id_q;
        end else begin
            winner = bus.req1;
        end
        sel_we    = winner ? bus.we1    : bus.we0;
        sel_addr  = winner ? bus.addr1  : bus.addr0;
        sel_wdata = winner ? bus.wdata1 : bus.wdata0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_read_d  = ~sel_we;
                    mem_write_d = sel_we;
                    grant_id_d  = winner;
                    cnt_d       = CW'(MEM_LAT - 1);
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // Memory read is combinational: capture on the last held cycle.
                    if (mem_read_q) begin
                        if (grant_id_q) rdata1_d = bus.mem_rdata;
                        else            rdata0_d = bus.mem_rdata;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (grant_id_q) ack1_d = 1'b1;
                    else            ack0_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops memory controls immediately
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            grant_id_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            grant_id_q  <= grant_id_d;
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.grant_id  = grant_id_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter at MEM_LAT = 1, 2 and 3.
// Latency: outputs sampled on the falling edge, inputs driven right after it.
// Backpressure: requests are held until the matching ack is observed.
module tb_dmem_port_arbiter;

    logic CLK;
    logic Reset_L;
    int   total = 0;
    int   bad   = 0;

    dmem_port_arbiter_if #(.AW(64), .DW(64)) if1 ();
    dmem_port_arbiter_if #(.AW(64), .DW(64)) if2 ();
    dmem_port_arbiter_if #(.AW(64), .DW(64)) if3 ();

    dmem_port_arbiter #(.AW(64), .DW(64), .MEM_LAT(1)) u_lat1 (
        .CLK(CLK), .Reset_L(Reset_L), .bus(if1)
    );
    dmem_port_arbiter #(.AW(64), .DW(64), .MEM_LAT(2)) u_lat2 (
        .CLK(CLK), .Reset_L(Reset_L), .bus(if2)
    );
    dmem_port_arbiter #(.AW(64), .DW(64), .MEM_LAT(3)) u_lat3 (
        .CLK(CLK), .Reset_L(Reset_L), .bus(if3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic clr_all();
        if1.req0 = 0; if1.we0 = 0; if1.addr0 = '0; if1.wdata0 = '0;
        if1.req1 = 0; if1.we1 = 0; if1.addr1 = '0; if1.wdata1 = '0; if1.mem_rdata = '0;
        if2.req0 = 0; if2.we0 = 0; if2.addr0 = '0; if2.wdata0 = '0;
        if2.req1 = 0; if2.we1 = 0; if2.addr1 = '0; if2.wdata1 = '0; if2.mem_rdata = '0;
        if3.req0 = 0; if3.we0 = 0; if3.addr0 = '0; if3.wdata0 = '0;
        if3.req1 = 0; if3.we1 = 0; if3.addr1 = '0; if3.wdata1 = '0; if3.mem_rdata = '0;
    endtask

    task automatic do_reset();
        Reset_L = 1'b0;
        step();
        step();
        Reset_L = 1'b1;
    endtask

    initial begin
        clr_all();
        Reset_L = 1'b0;
        step();
        step();

        // Reset values
        chk("rst_ack0",      64'(if1.ack0),      64'h0);
        chk("rst_ack1",      64'(if1.ack1),      64'h0);
        chk("rst_rdata0",    if1.rdata0,         64'h0);
        chk("rst_mem_read",  64'(if1.mem_read),  64'h0);
        chk("rst_mem_write", 64'(if1.mem_write), 64'h0);
        chk("rst_mem_addr",  if1.mem_addr,       64'h0);
        chk("rst_busy",      64'(if1.busy),      64'h0);
        chk("rst_grant_id",  64'(if1.grant_id),  64'h1);
        Reset_L = 1'b1;
        step();

        // 1: single read on port 0, MEM_LAT=1
        if1.req0 = 1; if1.we0 = 0; if1.addr0 = 64'h10; if1.mem_rdata = 64'hDEAD;
        step();
        chk("t1_busy_acc",  64'(if1.busy),     64'h1);
        chk("t1_mem_read",  64'(if1.mem_read), 64'h1);
        chk("t1_mem_addr",  if1.mem_addr,      64'h10);
        chk("t1_ack0_early",64'(if1.ack0),     64'h0);
        step();
        chk("t1_ack0",      64'(if1.ack0),     64'h1);
        chk("t1_rdata0",    if1.rdata0,        64'hDEAD);
        chk("t1_busy_done", 64'(if1.busy),     64'h1);
        chk("t1_read_off",  64'(if1.mem_read), 64'h0);
        if1.req0 = 0; if1.mem_rdata = 64'h0;
        step();
        chk("t1_ack0_off",  64'(if1.ack0),     64'h0);
        chk("t1_idle",      64'(if1.busy),     64'h0);
        chk("t1_rdata_hold",if1.rdata0,        64'hDEAD);

        // 2: simultaneous writes, port 0 first after reset
        do_reset();
        if1.req0 = 1; if1.we0 = 1; if1.addr0 = 64'h100; if1.wdata0 = 64'hA0;
        if1.req1 = 1; if1.we1 = 1; if1.addr1 = 64'h200; if1.wdata1 = 64'hB1;
        step();
        chk("t2_w0_write", 64'(if1.mem_write), 64'h1);
        chk("t2_w0_read",  64'(if1.mem_read),  64'h0);
        chk("t2_w0_addr",  if1.mem_addr,       64'h100);
        chk("t2_w0_data",  if1.mem_wdata,      64'hA0);
        chk("t2_w0_gid",   64'(if1.grant_id),  64'h0);
        step();
        chk("t2_ack0",     64'(if1.ack0),      64'h1);
        chk("t2_ack1_no",  64'(if1.ack1),      64'h0);
        chk("t2_w0_off",   64'(if1.mem_write), 64'h0);
        if1.req0 = 0;
        step();
        chk("t2_gap_busy", 64'(if1.busy),      64'h0);
        step();
        chk("t2_w1_write", 64'(if1.mem_write), 64'h1);
        chk("t2_w1_addr",  if1.mem_addr,       64'h200);
        chk("t2_w1_data",  if1.mem_wdata,      64'hB1);
        chk("t2_w1_gid",   64'(if1.grant_id),  64'h1);
        step();
        chk("t2_ack1",     64'(if1.ack1),      64'h1);
        chk("t2_ack0_no",  64'(if1.ack0),      64'h0);
        chk("t2_w1_off",   64'(if1.mem_write), 64'h0);
        if1.req1 = 0; if1.we0 = 0; if1.we1 = 0;
        step();

        // 3: both held for six accesses -> strict alternation
        do_reset();
        if1.req0 = 1; if1.req1 = 1; if1.addr0 = 64'h8; if1.addr1 = 64'h18;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t3_gid",      64'(if1.grant_id), 64'(i % 2));
            chk("t3_addr",     if1.mem_addr,      (i % 2 == 0) ? 64'h8 : 64'h18);
            step();
            chk("t3_ack0",     64'(if1.ack0),     (i % 2 == 0) ? 64'h1 : 64'h0);
            chk("t3_ack1",     64'(if1.ack1),     (i % 2 == 0) ? 64'h0 : 64'h1);
            if (i == 5) begin
                if1.req0 = 0; if1.req1 = 0;
            end
            step();
            chk("t3_idle",     64'(if1.busy),     64'h0);
        end

        // 4: MEM_LAT=3 write on port 1
        if3.req1 = 1; if3.we1 = 1; if3.addr1 = 64'h20; if3.wdata1 = 64'h55;
        for (int c = 1; c <= 3; c++) begin
            step();
            chk("t4_mem_write", 64'(if3.mem_write), 64'h1);
            chk("t4_ack1_wait", 64'(if3.ack1),      64'h0);
        end
        chk("t4_addr",  if3.mem_addr,  64'h20);
        chk("t4_wdata", if3.mem_wdata, 64'h55);
        step();
        chk("t4_ack1",      64'(if3.ack1),      64'h1);
        chk("t4_write_off", 64'(if3.mem_write), 64'h0);
        if3.req1 = 0; if3.we1 = 0;
        step();
        chk("t4_idle",      64'(if3.busy),      64'h0);

        // 5: reset mid-write at MEM_LAT=3
        if3.req0 = 1; if3.we0 = 1; if3.addr0 = 64'h44; if3.wdata0 = 64'h77;
        step();
        chk("t5_write_on", 64'(if3.mem_write), 64'h1);
        #2 Reset_L = 1'b0;
        #1;
        chk("t5_write_drop", 64'(if3.mem_write), 64'h0);
        chk("t5_busy_drop",  64'(if3.busy),      64'h0);
        chk("t5_addr_rst",   if3.mem_addr,       64'h0);
        chk("t5_wdata_rst",  if3.mem_wdata,      64'h0);
        chk("t5_gid_rst",    64'(if3.grant_id),  64'h1);
        chk("t5_rdata1_rst", if3.rdata1,         64'h0);
        if3.req0 = 0; if3.we0 = 0;
        step();
        Reset_L = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("t5_no_ack", 64'(if3.ack0), 64'h0);
        end

        // 6: req0 dropped during ACCESS at MEM_LAT=2
        if2.req0 = 1; if2.we0 = 0; if2.addr0 = 64'h30; if2.mem_rdata = 64'h1234;
        step();
        chk("t6_acc1_busy", 64'(if2.busy),     64'h1);
        if2.req0 = 0;
        step();
        chk("t6_acc2_busy", 64'(if2.busy),     64'h1);
        chk("t6_acc2_ack",  64'(if2.ack0),     64'h0);
        chk("t6_acc2_read", 64'(if2.mem_read), 64'h1);
        step();
        chk("t6_ack0",      64'(if2.ack0),     64'h1);
        chk("t6_rdata0",    if2.rdata0,        64'h1234);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t6_ack_once",  64'(if2.ack0), 64'h0);
            chk("t6_idle",      64'(if2.busy), 64'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
